// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Decoded scan-code event bundle from the PS/2 receiver.
interface ps2_scancode_rx_if;

  logic [7:0] code;
  logic       extended;
  logic       released;
  logic       valid;
  logic       err;

  modport master (
    output code,
    output extended,
    output released,
    output valid,
    output err
  );

  modport slave (
    input code,
    input extended,
    input released,
    input valid,
    input err
  );

endinterface

// File: rtl/ps2_filter.sv
// Synchronizer, glitch filter and falling-edge strobe for ps2_clk.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          s1_q;
  logic          s2_q;
  logic          filt_q;
  logic          filt_d;
  logic          fall_q;
  logic          fall_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= pin;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  // Level flips on the FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_scancode_rx_if.master ev
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          fall;
  logic          d1_q;
  logic          d2_q;
  ps2_state_e    state_q;
  ps2_state_e    state_d;
  logic [2:0]    bitcnt_q;
  logic [2:0]    bitcnt_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          par_q;
  logic          par_d;
  logic [TW-1:0] to_q;
  logic [TW-1:0] to_d;
  logic          ext_pend_q;
  logic          ext_pend_d;
  logic          rel_pend_q;
  logic          rel_pend_d;
  logic [7:0]    code_q;
  logic [7:0]    code_d;
  logic          ext_q;
  logic          ext_d;
  logic          rel_q;
  logic          rel_d;
  logic          valid_q;
  logic          valid_d;
  logic          err_q;
  logic          err_d;
  logic          timeout;
  logic          stop_fall;
  logic          good;

  ps2_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (ps2_clk),
    .fall    (fall)
  );

  // A fall in the expiry cycle keeps the frame alive.
  assign timeout = (state_q != IDLE) && !fall
                && (to_q == TW'(TIMEOUT - 1));

  assign stop_fall = (state_q == STOP) && fall;
  assign good = stop_fall && d2_q && odd_ones({shift_q, par_q});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1_q       <= 1'b1;
      d2_q       <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      d1_q       <= ps2_data;
      d2_q       <= d1_q;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_q       <= to_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    to_d     = '0;
    if (!fall && state_q != IDLE && !timeout)
      to_d = to_q + TW'(1);
    unique case (state_q)
      IDLE: begin
        if (fall && !d2_q) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d  = {d2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7)
            state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = d2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall)
          state_d = IDLE;
      end
    endcase
    if (timeout)
      state_d = IDLE;
  end

  always_comb begin
    code_d     = code_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    valid_d    = 1'b0;
    err_d      = (stop_fall && !good) || timeout;
    if (err_d) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (good) begin
      unique case (1'b1)
        (shift_q == PS2_EXT): ext_pend_d = 1'b1;
        (shift_q == PS2_REL): rel_pend_d = 1'b1;
        default: begin
          code_d     = shift_q;
          ext_d      = ext_pend_q;
          rel_d      = rel_pend_q;
          valid_d    = 1'b1;
          ext_pend_d = 1'b0;
          rel_pend_d = 1'b0;
        end
      endcase
    end
  end

  assign ev.code     = code_q;
  assign ev.extended = ext_q;
  assign ev.released = rel_q;
  assign ev.valid    = valid_q;
  assign ev.err      = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames, prefixes, errors, reset.
module tb_ps2_scancode_rx;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 40;

  logic clk;
  logic reset_n;
  logic ps2_clk;
  logic ps2_data;

  int nchk;
  int npass;
  int valid_cnt;
  int err_cnt;
  int both_cnt;

  ps2_scancode_rx_if dut_if ();

  ps2_scancode_rx #(
    .FILTER_LEN (FL),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev       (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut_if.valid) valid_cnt++;
    if (dut_if.err) err_cnt++;
    if (dut_if.valid && dut_if.err) both_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits);
    logic [10:0] f;
    logic p;
    p = (~^b) ^ bad_par;
    f = {1'b1, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    nchk++; if (dut_if.code !== 8'h00) $display("FAIL rst_code got %h want 00", dut_if.code); else npass++;
    nchk++; if (dut_if.extended !== 1'b0) $display("FAIL rst_ext got %b want 0", dut_if.extended); else npass++;
    nchk++; if (dut_if.released !== 1'b0) $display("FAIL rst_rel got %b want 0", dut_if.released); else npass++;
    nchk++; if (dut_if.valid !== 1'b0) $display("FAIL rst_valid got %b want 0", dut_if.valid); else npass++;
    nchk++; if (dut_if.err !== 1'b0) $display("FAIL rst_err got %b want 0", dut_if.err); else npass++;
  endtask

  task automatic test_make();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 1) $display("FAIL make_valid got %0d want 1", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.code !== 8'h1C) $display("FAIL make_code got %h want 1c", dut_if.code); else npass++;
    nchk++; if (dut_if.extended !== 1'b0) $display("FAIL make_ext got %b want 0", dut_if.extended); else npass++;
    nchk++; if (dut_if.released !== 1'b0) $display("FAIL make_rel got %b want 0", dut_if.released); else npass++;
    nchk++; if (err_cnt - e0 !== 0) $display("FAIL make_err got %0d want 0", err_cnt - e0); else npass++;
  endtask

  task automatic test_release();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hF0, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 0) $display("FAIL rel_prefix_valid got %0d want 0", valid_cnt - v0); else npass++;
    send_frame(8'h1C, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 1) $display("FAIL rel_valid got %0d want 1", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.code !== 8'h1C) $display("FAIL rel_code got %h want 1c", dut_if.code); else npass++;
    nchk++; if (dut_if.released !== 1'b1) $display("FAIL rel_rel got %b want 1", dut_if.released); else npass++;
    nchk++; if (dut_if.extended !== 1'b0) $display("FAIL rel_ext got %b want 0", dut_if.extended); else npass++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 1) $display("FAIL ext_valid got %0d want 1", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.code !== 8'h75) $display("FAIL ext_code got %h want 75", dut_if.code); else npass++;
    nchk++; if (dut_if.extended !== 1'b1) $display("FAIL ext_ext got %b want 1", dut_if.extended); else npass++;
    nchk++; if (dut_if.released !== 1'b1) $display("FAIL ext_rel got %b want 1", dut_if.released); else npass++;
    send_frame(8'h75, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 2) $display("FAIL plain_valid got %0d want 2", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.extended !== 1'b0) $display("FAIL plain_ext got %b want 0", dut_if.extended); else npass++;
    nchk++; if (dut_if.released !== 1'b0) $display("FAIL plain_rel got %b want 0", dut_if.released); else npass++;
  endtask

  task automatic test_parity_err();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b1, 11);
    nchk++; if (err_cnt - e0 !== 1) $display("FAIL par_err got %0d want 1", err_cnt - e0); else npass++;
    nchk++; if (valid_cnt - v0 !== 0) $display("FAIL par_valid got %0d want 0", valid_cnt - v0); else npass++;
    send_frame(8'h32, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 1) $display("FAIL par_next_valid got %0d want 1", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.code !== 8'h32) $display("FAIL par_next_code got %h want 32", dut_if.code); else npass++;
    nchk++; if (dut_if.released !== 1'b0) $display("FAIL par_next_rel got %b want 0", dut_if.released); else npass++;
    nchk++; if (err_cnt - e0 !== 1) $display("FAIL par_next_err got %0d want 1", err_cnt - e0); else npass++;
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h15, 1'b0, 6);
    repeat (TO + 10) @(negedge clk);
    nchk++; if (err_cnt - e0 !== 1) $display("FAIL to_err got %0d want 1", err_cnt - e0); else npass++;
    nchk++; if (valid_cnt - v0 !== 0) $display("FAIL to_valid got %0d want 0", valid_cnt - v0); else npass++;
    send_frame(8'h29, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 1) $display("FAIL to_next_valid got %0d want 1", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.code !== 8'h29) $display("FAIL to_next_code got %h want 29", dut_if.code); else npass++;
    nchk++; if (err_cnt - e0 !== 1) $display("FAIL to_next_err got %0d want 1", err_cnt - e0); else npass++;
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    nchk++; if (valid_cnt - v0 !== 0) $display("FAIL glitch_valid got %0d want 0", valid_cnt - v0); else npass++;
    send_frame(8'h1C, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 1) $display("FAIL glitch_next_valid got %0d want 1", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.code !== 8'h1C) $display("FAIL glitch_next_code got %h want 1c", dut_if.code); else npass++;
    nchk++; if (err_cnt - e0 !== 0) $display("FAIL glitch_err got %0d want 0", err_cnt - e0); else npass++;
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h5A, 1'b0, 4);
    v0 = valid_cnt; e0 = err_cnt;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nchk++; if (dut_if.code !== 8'h00) $display("FAIL rmid_code got %h want 00", dut_if.code); else npass++;
    reset_n = 1'b1;
    repeat (TO + 20) @(negedge clk);
    nchk++; if (err_cnt - e0 !== 0) $display("FAIL rmid_err got %0d want 0", err_cnt - e0); else npass++;
    nchk++; if (dut_if.extended !== 1'b0) $display("FAIL rmid_ext got %b want 0", dut_if.extended); else npass++;
    nchk++; if (dut_if.released !== 1'b0) $display("FAIL rmid_rel got %b want 0", dut_if.released); else npass++;
    nchk++; if (dut_if.valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", dut_if.valid); else npass++;
    send_frame(8'h1C, 1'b0, 11);
    nchk++; if (valid_cnt - v0 !== 1) $display("FAIL rmid_next_valid got %0d want 1", valid_cnt - v0); else npass++;
    nchk++; if (dut_if.code !== 8'h1C) $display("FAIL rmid_next_code got %h want 1c", dut_if.code); else npass++;
    nchk++; if (dut_if.extended !== 1'b0) $display("FAIL rmid_next_ext got %b want 0", dut_if.extended); else npass++;
  endtask

  initial begin
    nchk = 0; npass = 0;
    valid_cnt = 0; err_cnt = 0; both_cnt = 0;
    test_reset();
    test_make();
    test_release();
    test_back_to_back();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_reset_mid();
    nchk++; if (both_cnt !== 0) $display("FAIL valid_err_overlap got %0d want 0", both_cnt); else npass++;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
